// File: rtl/econet_hdlc_tx_if.sv
// +----------------------------------------------------------------------------+
// | Module      : econet_hdlc_tx_if                                            |
// | Description : Byte handshake, serial line and FCS signals of the Econet    |
// |               HDLC transmitter, bundled for the caller (master) and the    |
// |               transmitter core (slave).                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface econet_hdlc_tx_if;
  logic [7:0]  tx_byte;
  logic        start_frame;
  logic        end_frame;
  logic        request_byte;
  logic        econet_data;
  logic        transmitting;
  logic        fcs_clear;
  logic        fcs_enable;
  logic [7:0]  fcs_data;
  logic [15:0] fcsval;

  modport master (
    output tx_byte,
    output start_frame,
    output end_frame,
    output fcs_clear,
    output fcs_enable,
    output fcs_data,
    input  request_byte,
    input  econet_data,
    input  transmitting,
    input  fcsval
  );

  modport slave (
    input  tx_byte,
    input  start_frame,
    input  end_frame,
    input  fcs_clear,
    input  fcs_enable,
    input  fcs_data,
    output request_byte,
    output econet_data,
    output transmitting,
    output fcsval
  );
endinterface

`default_nettype wire

// File: rtl/econet_hdlc_tx.sv
// +----------------------------------------------------------------------------+
// | Module      : econet_hdlc_tx                                               |
// | Description : Econet bit-level HDLC transmitter: flag framing, LSB-first   |
// |               serialisation with zero-bit insertion, byte request          |
// |               handshake and an independent CRC-16/X.25 FCS accumulator.    |
// |               Define ECONET_TX_DOUBLE_FLAG_EN for two opening flags.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module econet_hdlc_tx #(
  parameter logic [7:0]  FLAG     = 8'h7E,
  parameter logic [15:0] FCS_INIT = 16'hFFFF,
  parameter logic [15:0] FCS_POLY = 16'h8408
) (
  input  wire logic       econet_clk,
  input  wire logic       reset,
  econet_hdlc_tx_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_OPEN_FLAG  = 2'd1,
    ST_DATA       = 2'd2,
    ST_CLOSE_FLAG = 2'd3
  } state_t;

`ifdef ECONET_TX_DOUBLE_FLAG_EN
  localparam logic c_last_open_pass = 1'b1;
`else
  localparam logic c_last_open_pass = 1'b0;
`endif

  state_t      r_state;
  logic        r_line;
  logic [7:0]  r_shift;
  logic [2:0]  r_idx;
  logic [2:0]  r_ones;
  logic        r_stuff;
  logic        r_pass;
  logic        r_close;
  logic [15:0] r_fcs;

  state_t      w_state_nxt;
  logic        w_line_nxt;
  logic [7:0]  w_shift_nxt;
  logic [2:0]  w_idx_nxt;
  logic [2:0]  w_ones_nxt;
  logic        w_stuff_nxt;
  logic        w_pass_nxt;
  logic        w_close_nxt;
  logic        w_req;

  logic        w_transmitting;
  logic [2:0]  w_idx_p1;
  logic        w_stuff_due;
  logic        w_open_done;
  logic        w_data_done;
  logic        w_at_boundary;

  assign w_transmitting = (r_state != ST_IDLE);
  assign w_idx_p1       = r_idx + 3'd1;
  // r_idx tracks the last data bit emitted; a stuff cycle leaves it in place
  assign w_stuff_due    = !r_stuff && (r_ones == 3'd5);
  assign w_open_done    = (r_idx == 3'd7) && (r_pass == c_last_open_pass);
  assign w_data_done    = (r_idx == 3'd7) && !w_stuff_due;
  assign w_at_boundary  = ((r_state == ST_OPEN_FLAG) && w_open_done) ||
                          ((r_state == ST_DATA) && w_data_done);

  always_comb begin
    w_state_nxt = r_state;
    w_line_nxt  = r_line;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_ones_nxt  = r_ones;
    w_stuff_nxt = r_stuff;
    w_pass_nxt  = r_pass;
    w_close_nxt = r_close | (bus.end_frame & w_transmitting);
    w_req       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_line_nxt = 1'b1;
        if (bus.start_frame) begin
          w_state_nxt = ST_OPEN_FLAG;
          w_line_nxt  = FLAG[0];
          w_idx_nxt   = 3'd0;
          w_pass_nxt  = 1'b0;
          w_ones_nxt  = 3'd0;
          w_stuff_nxt = 1'b0;
        end
      end
      ST_OPEN_FLAG: begin
        w_idx_nxt  = w_idx_p1;
        w_line_nxt = FLAG[w_idx_p1];
        if (r_idx == 3'd7) begin
          w_pass_nxt = 1'b1;
        end
      end
      ST_DATA: begin
        if (w_stuff_due) begin
          w_line_nxt  = 1'b0;
          w_stuff_nxt = 1'b1;
          w_ones_nxt  = 3'd0;
        end else begin
          w_idx_nxt   = w_idx_p1;
          w_line_nxt  = r_shift[w_idx_p1];
          w_ones_nxt  = r_shift[w_idx_p1] ? (r_ones + 3'd1) : 3'd0;
          w_stuff_nxt = 1'b0;
        end
      end
      ST_CLOSE_FLAG: begin
        if (r_idx == 3'd7) begin
          w_state_nxt = ST_IDLE;
          w_line_nxt  = 1'b1;
          w_close_nxt = 1'b0;
          w_ones_nxt  = 3'd0;
          w_stuff_nxt = 1'b0;
        end else begin
          w_idx_nxt  = w_idx_p1;
          w_line_nxt = FLAG[w_idx_p1];
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_line_nxt  = 1'b1;
      end
    endcase

    // Boundary overrides the per-state shift: either close or fetch a byte
    if (w_at_boundary) begin
      w_idx_nxt   = 3'd0;
      w_stuff_nxt = 1'b0;
      if (r_close) begin
        w_state_nxt = ST_CLOSE_FLAG;
        w_line_nxt  = FLAG[0];
        w_ones_nxt  = 3'd0;
      end else begin
        w_req       = 1'b1;
        w_state_nxt = ST_DATA;
        w_shift_nxt = bus.tx_byte;
        w_line_nxt  = bus.tx_byte[0];
        w_ones_nxt  = bus.tx_byte[0] ? (r_ones + 3'd1) : 3'd0;
      end
    end
  end

  always_ff @(posedge econet_clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_line  <= 1'b1;
      r_shift <= 8'h00;
      r_idx   <= 3'd0;
      r_ones  <= 3'd0;
      r_stuff <= 1'b0;
      r_pass  <= 1'b0;
      r_close <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_line  <= w_line_nxt;
      r_shift <= w_shift_nxt;
      r_idx   <= w_idx_nxt;
      r_ones  <= w_ones_nxt;
      r_stuff <= w_stuff_nxt;
      r_pass  <= w_pass_nxt;
      r_close <= w_close_nxt;
    end
  end

  function automatic logic [15:0] fcs_fold_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ data[i];
      c  = {1'b0, c[15:1]} ^ (fb ? FCS_POLY : 16'h0000);
    end
    return c;
  endfunction

  always_ff @(posedge econet_clk or posedge reset) begin
    if (reset) begin
      r_fcs <= FCS_INIT;
    end else if (bus.fcs_clear) begin
      r_fcs <= FCS_INIT;
    end else if (bus.fcs_enable) begin
      r_fcs <= fcs_fold_byte(r_fcs, bus.fcs_data);
    end
  end

  assign bus.request_byte = w_req;
  assign bus.econet_data  = r_line;
  assign bus.transmitting = w_transmitting;
  assign bus.fcsval       = r_fcs;

endmodule

`default_nettype wire

// File: tb/tb_econet_hdlc_tx.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_econet_hdlc_tx                                            |
// | Description : Self-checking bench for econet_hdlc_tx against a frame-level |
// |               bit-stream model and a message-level FCS model.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_econet_hdlc_tx;

`ifdef ECONET_TX_DOUBLE_FLAG_EN
  localparam int c_open_flags = 2;
`else
  localparam int c_open_flags = 1;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   passes;

  logic [7:0]  flag_pat;
  byte unsigned frame_bytes[$];
  byte unsigned fcs_msg[$];
  bit           m_bits[$];
  bit           m_req[$];
  bit           m_tx[$];

  econet_hdlc_tx_if bus ();

  econet_hdlc_tx dut (
    .econet_clk (clk),
    .reset      (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Expected line/request/transmitting per cycle, starting the cycle after start_frame
  task automatic push_entry(input bit b, input bit tx);
    m_bits.push_back(b);
    m_req.push_back(1'b0);
    m_tx.push_back(tx);
  endtask

  task automatic build_model();
    int          ones;
    logic [7:0]  cur;
    m_bits.delete();
    m_req.delete();
    m_tx.delete();
    for (int f = 0; f < c_open_flags; f++)
      for (int b = 0; b < 8; b++) push_entry(flag_pat[b], 1'b1);
    ones = 0;
    foreach (frame_bytes[i]) begin
      m_req[m_req.size() - 1] = 1'b1;
      cur = frame_bytes[i];
      for (int b = 0; b < 8; b++) begin
        push_entry(cur[b], 1'b1);
        ones = cur[b] ? ones + 1 : 0;
        if (ones == 5) begin
          push_entry(1'b0, 1'b1);
          ones = 0;
        end
      end
    end
    for (int b = 0; b < 8; b++) push_entry(flag_pat[b], 1'b1);
    push_entry(1'b1, 1'b0);
  endtask

  function automatic logic [15:0] crc_ref();
    bit          bits[$];
    logic [7:0]  tmp;
    logic [15:0] crc;
    bit          fb;
    foreach (fcs_msg[i]) begin
      tmp = fcs_msg[i];
      for (int b = 0; b < 8; b++) bits.push_back(tmp[b]);
    end
    crc = 16'hFFFF;
    foreach (bits[i]) begin
      fb  = crc[0] ^ bits[i];
      crc = (crc >> 1) ^ (fb ? 16'h8408 : 16'h0000);
    end
    return crc;
  endfunction

  // Runs one frame of frame_bytes; call just after a rising edge with the DUT idle
  task automatic run_frame(input int restart_at, input bit chained, input bit next_start);
    int n;
    int last;
    int reqcnt;
    bit req_seen;
    n = frame_bytes.size();
    build_model();
    last   = m_bits.size() - 1;
    reqcnt = 0;
    bus.tx_byte = (n > 0) ? frame_bytes[0] : 8'h00;
    if (!chained) begin
      bus.start_frame = 1'b1;
      @(posedge clk); #1;
    end
    bus.start_frame = 1'b0;
    bus.end_frame   = (n == 0);
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      checks++;
      if (bus.econet_data !== m_bits[k])
        $display("FAIL line_bit cycle %0d: got %b expected %b", k, bus.econet_data, m_bits[k]);
      else passes++;
      checks++;
      if (bus.request_byte !== m_req[k])
        $display("FAIL request_byte cycle %0d: got %b expected %b", k, bus.request_byte, m_req[k]);
      else passes++;
      checks++;
      if (bus.transmitting !== m_tx[k])
        $display("FAIL transmitting cycle %0d: got %b expected %b", k, bus.transmitting, m_tx[k]);
      else passes++;
      req_seen = bus.request_byte;
      @(posedge clk); #1;
      bus.end_frame   = 1'b0;
      bus.start_frame = ((k + 1) == restart_at) || (next_start && (k == last - 1));
      if (req_seen) begin
        reqcnt++;
        if (reqcnt < n) bus.tx_byte = frame_bytes[reqcnt];
        else bus.end_frame = 1'b1;
      end
    end
  endtask

  task automatic fill_random(input int n);
    frame_bytes.delete();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) frame_bytes.push_back(8'hFF ^ (8'h01 << $urandom_range(0, 7)));
      else frame_bytes.push_back(8'($urandom));
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.econet_data !== 1'b1) $display("FAIL reset_line: got %b expected 1", bus.econet_data); else passes++;
    checks++;
    if (bus.transmitting !== 1'b0) $display("FAIL reset_tx: got %b expected 0", bus.transmitting); else passes++;
    checks++;
    if (bus.request_byte !== 1'b0) $display("FAIL reset_req: got %b expected 0", bus.request_byte); else passes++;
    checks++;
    if (bus.fcsval !== 16'hFFFF) $display("FAIL reset_fcs: got %h expected ffff", bus.fcsval); else passes++;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.econet_data, bus.transmitting, bus.request_byte} !== 3'b100 || bus.fcsval !== 16'hFFFF)
        $display("FAIL post_reset_idle: got %b%b%b/%h expected 100/ffff",
                 bus.econet_data, bus.transmitting, bus.request_byte, bus.fcsval);
      else passes++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_min_frame();
    frame_bytes.delete();
    run_frame(0, 1'b0, 1'b0);
  endtask

  task automatic test_zero_byte();
    frame_bytes.delete();
    frame_bytes.push_back(8'h00);
    run_frame(0, 1'b0, 1'b0);
  endtask

  task automatic test_stuffing();
    frame_bytes.delete();
    frame_bytes.push_back(8'hFF);
    frame_bytes.push_back(8'h00);
    run_frame(0, 1'b0, 1'b0);
    frame_bytes.delete();
    frame_bytes.push_back(8'hF8);
    frame_bytes.push_back(8'h0F);
    frame_bytes.push_back(8'hFF);
    run_frame(0, 1'b0, 1'b0);
  endtask

  task automatic test_fcs();
    string s;
    s = "123456789";
    bus.fcs_clear = 1'b1;
    @(posedge clk); #1;
    bus.fcs_clear = 1'b0;
    checks++;
    if (bus.fcsval !== 16'hFFFF) $display("FAIL fcs_clear: got %h expected ffff", bus.fcsval); else passes++;
    for (int i = 0; i < 9; i++) begin
      bus.fcs_enable = 1'b1;
      bus.fcs_data   = s[i];
      @(posedge clk); #1;
    end
    bus.fcs_enable = 1'b0;
    checks++;
    if (bus.fcsval !== 16'h6F91) $display("FAIL fcs_check_string: got %h expected 6f91", bus.fcsval); else passes++;
    for (int r = 0; r < 3; r++) begin
      bus.fcs_clear = 1'b1;
      @(posedge clk); #1;
      bus.fcs_clear = 1'b0;
      fcs_msg.delete();
      for (int j = 0; j < int'($urandom_range(1, 10)); j++) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.fcs_enable = 1'b0;
          bus.fcs_data   = 8'($urandom);
          @(posedge clk); #1;
        end
        bus.fcs_enable = 1'b1;
        bus.fcs_data   = 8'($urandom);
        fcs_msg.push_back(bus.fcs_data);
        @(posedge clk); #1;
        bus.fcs_enable = 1'b0;
        checks++;
        if (bus.fcsval !== crc_ref())
          $display("FAIL fcs_random round %0d byte %0d: got %h expected %h", r, j, bus.fcsval, crc_ref());
        else passes++;
      end
    end
    bus.fcs_clear  = 1'b1;
    bus.fcs_enable = 1'b1;
    bus.fcs_data   = 8'h5A;
    @(posedge clk); #1;
    bus.fcs_clear  = 1'b0;
    bus.fcs_enable = 1'b0;
    checks++;
    if (bus.fcsval !== 16'hFFFF) $display("FAIL fcs_clear_wins: got %h expected ffff", bus.fcsval); else passes++;
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 6; f++) begin
      fill_random(int'($urandom_range(0, 4)));
      run_frame(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 14)) : 0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    fill_random(2);
    run_frame(0, 1'b0, 1'b1);
    fill_random(1);
    run_frame(5, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    bus.tx_byte     = 8'hA5;
    bus.start_frame = 1'b1;
    @(posedge clk); #1;
    bus.start_frame = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bus.end_frame = 1'b1;
    @(posedge clk); #1;
    bus.end_frame = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.econet_data, bus.transmitting, bus.request_byte} !== 3'b100)
      $display("FAIL abort_immediate: got %b%b%b expected 100", bus.econet_data, bus.transmitting, bus.request_byte);
    else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.econet_data, bus.transmitting, bus.request_byte} !== 3'b100)
        $display("FAIL abort_idle cycle %0d: got %b%b%b expected 100", i,
                 bus.econet_data, bus.transmitting, bus.request_byte);
      else passes++;
    end
    @(posedge clk); #1;
    fill_random(2);
    run_frame(0, 1'b0, 1'b0);
  endtask

  initial begin
    clk             = 1'b0;
    rst             = 1'b1;
    checks          = 0;
    passes          = 0;
    flag_pat        = 8'h7E;
    bus.tx_byte     = 8'h00;
    bus.start_frame = 1'b0;
    bus.end_frame   = 1'b0;
    bus.fcs_clear   = 1'b0;
    bus.fcs_enable  = 1'b0;
    bus.fcs_data    = 8'h00;
    test_reset();
    test_min_frame();
    test_zero_byte();
    test_stuffing();
    test_fcs();
    test_random_frames();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/econet_hdlc_tx.md
Name: econet_hdlc_tx

Overview:
- Bit-level Econet (HDLC-framed) transmitter core, clocked by the Econet bit clock.
- Serialises caller-supplied bytes LSB-first, framed by 0x7E flags, with zero-bit insertion. Exposes a byte-request handshake.
- Contains an independent byte-parallel CRC-16/X.25 FCS accumulator. The buffering/sequencing layer above uses it to compute the FCS bytes that it then feeds back as ordinary data.

Parameters:
- FLAG, 8'h7E, opening/closing flag pattern, never bit-stuffed.
- FCS_INIT, 16'hFFFF, FCS register value after reset/clear.
- FCS_POLY, 16'h8408, reflected CRC-CCITT polynomial.

Ports:
- econet_clk  in  1  bit clock; one line bit per rising edge.
- reset  in  1  asynchronous, active-high; one clock (econet_clk).
- tx_byte  in  8  next byte to send; sampled in the request_byte cycle.
- start_frame  in  1  begin frame; honoured only when idle.
- end_frame  in  1  close frame after the current byte.
- request_byte  out  1  one-cycle pulse: tx_byte consumed this cycle.
- econet_data  out  1  registered serial line output.
- transmitting  out  1  high while a frame (flags included) is on the line.
- fcs_clear  in  1  synchronous load of FCS_INIT.
- fcs_enable  in  1  fold fcs_data into the FCS this cycle.
- fcs_data  in  8  byte to accumulate.
- fcsval  out  16  raw FCS register, not inverted.

Behaviour:
- Reset values: econet_data=1, transmitting=0, request_byte=0, fcsval=FFFF. Internal FSM goes to IDLE, the sticky close flag is cleared, and the ones counter is zeroed. Reset mid-frame aborts immediately with no closing flag.
- FSM states: IDLE, OPEN_FLAG, DATA, CLOSE_FLAG.
- IDLE:
  - Line is held at 1.
  - start_frame high on edge N → OPEN_FLAG. transmitting=1 and flag bit0 appear on the line at N+1.
- OPEN_FLAG: shift FLAG LSB-first over 8 cycles (0,1,1,1,1,1,1,0). No stuffing; the ones counter is cleared.
- Byte boundary (cycle in which the last bit of the current flag/byte is on the line):
  - If the close flag is set → CLOSE_FLAG. No request is issued.
  - Otherwise request_byte=1 for that cycle and tx_byte is loaded. Its bit0 drives the line next cycle → DATA.
- DATA:
  - Shift LSB-first and count consecutive 1 bits.
  - After five consecutive 1s, insert one 0 bit: the shifter holds one cycle and the counter resets. A 0 data bit also resets the counter.
  - A stuff bit owed after a byte's last bit is emitted before the boundary, delaying request_byte by one cycle.
- end_frame:
  - Captured into a sticky close flag on any cycle it is high while transmitting=1.
  - Takes effect at the next boundary.
  - Cleared on return to IDLE.
- CLOSE_FLAG:
  - 8 flag bits, unstuffed.
  - The cycle after the last flag bit: transmitting=0, econet_data=1, FSM in IDLE.
  - A new start_frame is accepted in that same cycle.
- start_frame while not in IDLE is ignored. Minimum frame is open flag + close flag (end_frame asserted during the open flag).
- FCS, per edge:
  - fcs_clear → FCS_INIT. Clear wins over fcs_enable.
  - Otherwise, if fcs_enable: fcs_data is processed in one cycle as eight serial steps, LSB first. Each step: fb = crc[0]^bit; crc = crc>>1; if fb, crc ^= FCS_POLY.
  - fcsval updates on the edge after the enable.
- The FCS path is fully independent of the serialiser. Transmitted FCS bytes are ~fcsval[7:0] then ~fcsval[15:8], supplied by the user via tx_byte.

Optional Feature:
- Macro: ECONET_TX_DOUBLE_FLAG_EN.
- Defined: OPEN_FLAG sends two back-to-back FLAG bytes (16 cycles) before the first request_byte.
- Undefined: exactly one opening flag.
- The closing flag count is unaffected either way.

Test Plan:
1. Reset asserted → econet_data=1, transmitting=0, request_byte=0, fcsval=16'hFFFF. Reset released → all unchanged until start_frame.
2. start_frame pulse; tx_byte=8'h00; end_frame pulsed right after the first request → line 01111110 00000000 01111110 then 1; request_byte exactly once, in the 8th flag cycle; transmitting high for exactly 24 cycles.
3. tx_byte=8'hFF, then 8'h00, then end → data bits 11111 0 111 (9 cycles), second request 9 cycles after the first, stuffed bit present; closing flag unstuffed.
4. fcs_clear, then fcs_enable with ASCII "123456789" on consecutive cycles → fcsval=16'h6F91 (~16'h906E). Clear+enable together → FFFF.
5. Reset asserted mid-DATA → next cycle transmitting=0, econet_data=1, no further request_byte. A later start_frame produces a clean full frame.
6. start_frame re-pulsed mid-frame → ignored, bit stream unchanged. Build with ECONET_TX_DOUBLE_FLAG_EN → first request in cycle 16.
